// File: rtl/timer_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
package timer_pkg;

  typedef enum logic {IDLE, RUN} timer_state_t;

  localparam int TIMER_W = 32;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable N-bit down counter with one-shot and periodic (auto-reload) modes.
// The FSM state is observable on running (high exactly while in RUN).
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int N = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  input  logic         periodic,
  output logic [N-1:0] q,
  output logic         running,
  output logic         expired
);

  logic [N-1:0] r_q;
  logic [N-1:0] r_reload;
  timer_state_t r_state;
  logic         r_expired;

  logic [N-1:0] w_q_next;
  logic [N-1:0] w_reload_next;
  timer_state_t w_state_next;
  logic         w_expired_next;

  // load outranks every counting/terminal action; the q == 1 rule keeps q off underflow.
  always_comb begin
    w_q_next       = r_q;
    w_reload_next  = r_reload;
    w_state_next   = r_state;
    w_expired_next = 1'b0;
    if (load) begin
      w_q_next      = load_value;
      w_reload_next = load_value;
      w_state_next  = (load_value != '0) ? RUN : IDLE;
    end else if (r_state == RUN && enable) begin
      if (r_q == N'(1)) begin
        w_expired_next = 1'b1;
        if (periodic) begin
          w_q_next = r_reload;
        end else begin
          w_q_next     = '0;
          w_state_next = IDLE;
        end
      end else if (r_q != '0) begin
        w_q_next = r_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      r_reload  <= '0;
      r_state   <= IDLE;
      r_expired <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_reload  <= w_reload_next;
      r_state   <= w_state_next;
      r_expired <= w_expired_next;
    end
  end

  assign q       = r_q;
  assign expired = r_expired;
  assign running = (r_state == RUN);

endmodule
